data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Data-memory responder on the far end of the MEM-stage memory interface. The pipeline's memWrite/result/ddr bundle from the EX/MEM register is the initiator side.
- Accepts one read or write request at a time and services it after a programmable wait latency. Holds `stall` high so the pipeline freezes until the response is ready.
- Returns read data (or echoes write data) with a one-cycle `respValid` pulse, which feeds the MEM/WB register's data input.

Parameters:
- DATA_W, 32, data word width
- ADDR_W, 32, byte-address width of ddr
- DEPTH, 256, number of DATA_W words in the array (power of two, 4..4096)
- LATENCY, 2, cycles from acceptance to response (legal 1..15)

Ports:
- Clk  in  1  clock; all state changes on posedge
- Rst  in  1  synchronous active-high reset
- reqValid  in  1  MEM stage presents a request; held stable while stall is high
- reqWrite  in  1  1 = store, 0 = load (memWrite)
- reqAddr  in  ADDR_W  byte address (ddr)
- reqData  in  DATA_W  store data
- stall  out  1  combinational; pipeline must hold all stages this cycle
- respValid  out  1  registered; response valid this cycle (single-cycle pulse)
- respData  out  DATA_W  registered; load data, or store data echoed
- respErr  out  1  registered; valid with respValid; misaligned or out-of-range access

Behaviour:
- Reset (Rst high at posedge):
  - state=IDLE, counter=0, respValid=0, respData=0, respErr=0.
  - Array contents are not cleared.
  - Reset mid-request aborts the request; a pending store is not performed.
- Word index = reqAddr[ADDR_W-1:2]. The access is in error if reqAddr[1:0]!=0 or index>=DEPTH.
- States:
  - IDLE: if reqValid, then at the posedge accept the request. Latch write/addr/data, set counter=LATENCY-1, go to WAIT if LATENCY>1, else go to RESP.
  - WAIT: decrement the counter each posedge; when counter==1, go to RESP on that edge.
  - RESP: respValid=1 for exactly this cycle; reqValid is ignored; the next posedge returns to IDLE.
- Edge entering RESP:
  - Store without error: mem[index]<=latched data, respData<=latched data.
  - Load without error: respData<=mem[index].
  - Error: no array write, respData<=0, respErr<=1.
- respValid and respErr are 0 in every state except RESP. respData holds its last value outside RESP.
- stall = (state==IDLE && reqValid) || state==WAIT. stall is 0 in RESP, so the pipeline advances at the end of the RESP cycle.
- Request timing:
  - A request occupies LATENCY+1 cycles: 1 accept cycle plus LATENCY-1 WAIT cycles plus 1 RESP cycle.
  - With LATENCY=1: accept cycle (stall=1), then RESP cycle (stall=0).
- Back-to-back requests: a reqValid seen in the IDLE cycle after RESP is a new request; there are no idle bubbles required.
- Changes on req* while stall=1 are illegal and are not checked. Latched values are used.
- Store followed by a load to the same address returns the new data. There is no bypass issue because requests are serialized.

Test Plan:
- Reset, then idle with reqValid=0 for 5 cycles -> stall=0, respValid=0, respData=0, respErr=0 throughout.
- LATENCY=2: store 0xDEADBEEF to 0x10, then load 0x10 -> each request sees stall high for 2 cycles then respValid for 1 cycle; load respData=0xDEADBEEF, respErr=0.
- LATENCY=1: loads to 0x0, 0x4, 0x8 presented back-to-back after stores of 1, 2, 3 -> responses 1, 2, 3 on alternating cycles; stall pattern 1,0,1,0,1,0.
- Misaligned store to 0x12 with 0x5, then load from 0x10 -> store gives respErr=1 and respData=0; load returns the prior 0xDEADBEEF unchanged.
- DEPTH=256, load from 0x400 -> respErr=1, respData=0, no hang; FSM back in IDLE the next cycle.
- LATENCY=4: store 0xCAFE to 0x20, assert Rst during the second WAIT cycle, then load 0x20 -> outputs clear at that edge; the load does not return 0xCAFE (old contents preserved); the load completes with a normal 4-cycle stall.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: serialized load/store responder with programmable wait latency for the MEM stage
module data_mem_responder #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              reqValid,
    input  logic              reqWrite,
    input  logic [ADDR_W-1:0] reqAddr,
    input  logic [DATA_W-1:0] reqData,
    output logic              stall,
    output logic              respValid,
    output logic [DATA_W-1:0] respData,
    output logic              respErr
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] WORDS = ADDR_W'(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state;
    logic [3:0] cnt;
    logic lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic [DATA_W-1:0] mem [DEPTH];
    logic acc_write, acc_err, go_resp;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;
    logic [IDX_W-1:0] acc_idx;
    // the access runs on the edge entering RESP; from IDLE (LATENCY=1) that edge still sees the live request
    always_comb begin
        acc_write = (state == IDLE) ? reqWrite : lat_write;
        acc_addr  = (state == IDLE) ? reqAddr : lat_addr;
        acc_data  = (state == IDLE) ? reqData : lat_data;
        acc_idx   = acc_addr[IDX_W+1:2];
        acc_err   = (acc_addr[1:0] != 2'b00) || ((acc_addr >> 2) >= WORDS);
        go_resp   = (state == IDLE) ? (reqValid && LATENCY == 1) : (state == WAIT && cnt == 4'd1);
        stall     = (state == IDLE && reqValid) || state == WAIT;
    end
    // request fields are captured once at acceptance and held for the whole wait
    always_ff @(posedge Clk) begin
        if (state == IDLE && reqValid) begin
            lat_write <= reqWrite;
            lat_addr  <= reqAddr;
            lat_data  <= reqData;
        end
    end
    // array write; a reset on the completing edge cancels the store
    always_ff @(posedge Clk) begin
        if (!Rst && go_resp && acc_write && !acc_err)
            mem[acc_idx] <= acc_data;
    end
    // control FSM with registered response outputs
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            cnt       <= '0;
            respValid <= 1'b0;
            respData  <= '0;
            respErr   <= 1'b0;
        end else begin
            respValid <= go_resp;
            respErr   <= go_resp && acc_err;
            if (go_resp)
                respData <= acc_err ? '0 : acc_write ? acc_data : mem[acc_idx];
            case (state)
                IDLE: if (reqValid) begin
                    cnt   <= CNT_INIT;
                    state <= (LATENCY > 1) ? WAIT : RESP;
                end
                WAIT: begin
                    cnt   <= cnt - 4'd1;
                    state <= (cnt == 4'd1) ? RESP : WAIT;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
